// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency reads to the
// instruction cache and buffers returned words in a 2-entry skid FIFO for decode.
module inst_fetch #(
  parameter int                 ADDR_W   = 5,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLOCK_50,
  input  logic              RSTN_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              in_flight_q, in_flight_d;
  logic [1:0]        count_q, count_d;
  entry_t            fifo_q [2];
  entry_t            fifo_d [2];

  logic       pop, push, issue;
  logic [2:0] occupancy;
  logic [1:0] cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pc_d        = pc_q;
    tag_d       = tag_q;
    in_flight_d = in_flight_q;
    count_d     = count_q;
    fifo_d      = fifo_q;
    cnt         = count_q;

    pop       = (count_q != 2'd0) & id_ready & ~redirect_valid;
    push      = in_flight_q & ~redirect_valid;
    occupancy = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop};
    issue     = redirect_valid | (occupancy < 3'd2);

    if (redirect_valid) begin
      // Wrong-path words in the FIFO and the returning response are dropped.
      count_d     = 2'd0;
      pc_d        = redirect_pc + ADDR_W'(1);
      tag_d       = redirect_pc;
      in_flight_d = 1'b1;
    end else begin
      // Shift out the head first, then write the response behind what remains.
      if (pop) begin
        fifo_d[0] = fifo_q[1];
        cnt       = cnt - 2'd1;
      end
      if (push) begin
        if (cnt == 2'd0) fifo_d[0] = '{pc: tag_q, inst: imem_rdata};
        else             fifo_d[1] = '{pc: tag_q, inst: imem_rdata};
        cnt = cnt + 2'd1;
      end
      count_d     = cnt;
      in_flight_d = issue;
      if (issue) begin
        tag_d = pc_q;
        pc_d  = pc_q + ADDR_W'(1);
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if redirect is asserted.
  assign imem_req  = RSTN_N & issue;
  assign imem_addr = (RSTN_N & redirect_valid) ? redirect_pc : pc_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_inst   = if_valid ? fifo_q[0].inst : '0;
  assign if_pc     = if_valid ? fifo_q[0].pc   : '0;

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      pc_q        <= RESET_PC;
      tag_q       <= '0;
      in_flight_q <= 1'b0;
      count_q     <= 2'd0;
      // NOTE: the two FIFO slots are tiny, so they are reset too; this keeps
      // if_inst/if_pc free of X even though count already masks them.
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      pc_q        <= pc_d;
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule
